// File: rtl/pw_weight_feeder_pkg.sv
// Shared definitions for the pointwise weight/bias feeder: FSM encoding and
// the filter-slot phase constants.
package pw_weight_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2
    } feeder_state_e;

    // Cycles per filter slot; must equal the pointwise stage's fine counter length.
    localparam int PHASE_LEN_DEF = 18;

    // Phase at which the next filter is fetched into the output registers.
    function automatic int phase_fetch(input int phase_len);
        return phase_len - 2;
    endfunction

    // Phase at which the consumer samples the freshly fetched filter.
    function automatic int phase_last(input int phase_len);
        return phase_len - 1;
    endfunction

endpackage

// File: rtl/pw_weight_feeder_param_rf.sv
// FILTER_NUM-deep parameter register file: one synchronous write port and one
// combinational read port, so a same-edge write is seen by the next cycle's read.
module pw_param_rf #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 272,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; its contents are only meaningful
    // once the loader has written them, and a reset tree here would be wasted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pw_weight_feeder.sv
// Streams one 1x1 filter row plus bias per slot to the pointwise stage, in
// lock-step with its PHASE_LEN-cycle cadence. Optional start-while-busy
// detection is built when PW_FEEDER_ERR_EN is defined.
module pw_weight_feeder
    import pw_weight_feeder_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IN_CH      = 32,
    parameter int BIAS_W     = 16,
    parameter int FILTER_NUM = 32,
    parameter int PHASE_LEN  = PHASE_LEN_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          wr_en_i,
    input  logic [$clog2(FILTER_NUM)-1:0] wr_addr_i,
    input  logic [IN_CH*DATA_W-1:0]       wr_weight_i,
    input  logic [BIAS_W-1:0]             wr_bias_i,
    output logic [IN_CH*DATA_W-1:0]       weight_o,
    output logic [BIAS_W-1:0]             bias_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overrun_o
);

    localparam int AW   = $clog2(FILTER_NUM);
    localparam int WW   = IN_CH * DATA_W;
    localparam int RF_W = WW + BIAS_W;
    localparam int PW   = $clog2(PHASE_LEN + 1);

    localparam logic [PW-1:0] PH_ONE   = PW'(1);
    localparam logic [PW-1:0] PH_END   = PW'(PHASE_LEN);
    localparam logic [PW-1:0] PH_FETCH = PW'(phase_fetch(PHASE_LEN));
    localparam logic [PW-1:0] PH_LAST  = PW'(phase_last(PHASE_LEN));
    localparam logic [AW-1:0] IDX_LAST = AW'(FILTER_NUM - 1);

    feeder_state_e   state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            load_out;
    logic [AW-1:0]   rd_addr;
    logic [RF_W-1:0] rd_data;
    logic [WW-1:0]   weight_q;
    logic [BIAS_W-1:0] bias_q;
    logic [PW-1:0]   phase_inc;

    pw_param_rf #(
        .DEPTH (FILTER_NUM),
        .WIDTH (RF_W),
        .AW    (AW)
    ) u_rf (
        .clk     (clk),
        .wr_en   (wr_en_i),
        .wr_addr (wr_addr_i),
        .wr_data ({wr_bias_i, wr_weight_i}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign phase_inc = (phase_q == PH_END) ? PH_ONE : phase_q + PH_ONE;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        load_out = 1'b0;
        rd_addr  = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Entry 0 is re-staged every cycle so the first filter is always current.
                load_out = 1'b1;
                phase_d  = '0;
                idx_d    = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                    phase_d = PH_ONE;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                phase_d = phase_inc;
                if (phase_q == PH_FETCH && idx_q < IDX_LAST) begin
                    idx_d    = idx_q + AW'(1);
                    rd_addr  = idx_q + AW'(1);
                    load_out = 1'b1;
                end
                if (phase_q == PH_LAST && idx_q == IDX_LAST) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                // Last filter held for one full slot; phase comes back to PH_LAST after PHASE_LEN edges.
                phase_d = phase_inc;
                if (phase_q == PH_LAST) begin
                    state_d  = ST_IDLE;
                    phase_d  = '0;
                    idx_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    load_out = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            weight_q <= '0;
            bias_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (load_out) begin
                {bias_q, weight_q} <= rd_data;
            end
        end
    end

    assign weight_o = weight_q;
    assign bias_o   = bias_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

`ifdef PW_FEEDER_ERR_EN
    logic overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (start_i && state_q != ST_IDLE) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_o = overrun_q;
`else
    assign overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_pw_weight_feeder.sv
// Directed self-checking bench for pw_weight_feeder: stream timing, rewrites,
// overrun handling, mid-stream reset and back-to-back layers.
module tb_pw_weight_feeder;

    localparam int DATA_W     = 8;
    localparam int IN_CH      = 32;
    localparam int BIAS_W     = 16;
    localparam int FILTER_NUM = 32;
    localparam int PH         = 18;
    localparam int AW         = $clog2(FILTER_NUM);
    localparam int WW         = IN_CH * DATA_W;
    localparam int STREAM_END = PH * FILTER_NUM;       // done_o observed before edge T+576
    localparam int LAST_SMP   = PH * FILTER_NUM - 19;  // last filter sampled at T+557

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic              wr_en_i = 1'b0;
    logic [AW-1:0]     wr_addr_i = '0;
    logic [WW-1:0]     wr_weight_i = '0;
    logic [BIAS_W-1:0] wr_bias_i = '0;
    logic [WW-1:0]     weight_o;
    logic [BIAS_W-1:0] bias_o;
    logic              busy_o;
    logic              done_o;
    logic              overrun_o;

    int tests = 0;
    int fails = 0;

    logic [WW-1:0]     mdl_w  [FILTER_NUM];
    logic [BIAS_W-1:0] mdl_b  [FILTER_NUM];
    logic [WW-1:0]     pres_w [FILTER_NUM];
    logic [BIAS_W-1:0] pres_b [FILTER_NUM];

    pw_weight_feeder #(
        .DATA_W     (DATA_W),
        .IN_CH      (IN_CH),
        .BIAS_W     (BIAS_W),
        .FILTER_NUM (FILTER_NUM),
        .PHASE_LEN  (PH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_weight_i (wr_weight_i),
        .wr_bias_i   (wr_bias_i),
        .weight_o    (weight_o),
        .bias_o      (bias_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; the write lands on the next posedge.
    task automatic write_entry(input int idx, input logic [7:0] b, input logic [BIAS_W-1:0] bias);
        wr_en_i     = 1'b1;
        wr_addr_i   = AW'(idx);
        wr_weight_i = {IN_CH{b}};
        wr_bias_i   = bias;
        @(negedge clk);
        wr_en_i     = 1'b0;
        mdl_w[idx]  = {IN_CH{b}};
        mdl_b[idx]  = bias;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        tests++;
        if (weight_o !== '0) begin
            fails++;
            $display("FAIL %s weight: got %h want 0", tag, weight_o);
        end
        tests++;
        if (bias_o !== '0) begin
            fails++;
            $display("FAIL %s bias: got %h want 0", tag, bias_o);
        end
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL %s busy/done: got %b/%b want 0/0", tag, busy_o, done_o);
        end
        tests++;
        if (overrun_o !== 1'b0) begin
            fails++;
            $display("FAIL %s overrun: got %b want 0", tag, overrun_o);
        end
    endtask

    // Called at a negedge; start is taken on the following edge T. Returns at the
    // negedge before T+576, where done_o should be visible.
    task automatic run_stream(input string tag, input int wr_at, input int wr_idx,
                              input logic [7:0] wr_byte, input int restart_at);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        for (int k = 0; k < FILTER_NUM; k++) begin
            pres_w[k] = mdl_w[k];
            pres_b[k] = mdl_b[k];
        end
        start_i = 1'b1;
        for (int e = 0; e <= STREAM_END; e++) begin
            if (e == 0 || ((e + 1) % PH == 0 && e <= LAST_SMP)) begin
                int k = (e + 1) / PH;
                tests++;
                if (weight_o !== pres_w[k]) begin
                    fails++;
                    $display("FAIL %s weight f%0d @T+%0d: got %h want %h", tag, k, e, weight_o[31:0], pres_w[k][31:0]);
                end
                tests++;
                if (bias_o !== pres_b[k]) begin
                    fails++;
                    $display("FAIL %s bias f%0d @T+%0d: got %0d want %0d", tag, k, e, bias_o, pres_b[k]);
                end
            end
            if (e > 0) begin
                if (busy_o === 1'b1) busy_cnt++;
                if (done_o === 1'b1) begin
                    done_cnt++;
                    done_at = e;
                end
            end
            if (e == STREAM_END) break;
            if (e == wr_at) begin
                wr_en_i     = 1'b1;
                wr_addr_i   = AW'(wr_idx);
                wr_weight_i = {IN_CH{wr_byte}};
                wr_bias_i   = mdl_b[wr_idx];
                mdl_w[wr_idx] = {IN_CH{wr_byte}};
                // Only a filter fetched strictly after the write edge sees the new data.
                if (wr_idx != 0 && PH * wr_idx - 2 > wr_at) pres_w[wr_idx] = {IN_CH{wr_byte}};
            end
            if (e == restart_at) start_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
            wr_en_i = 1'b0;
        end
        tests++;
        if (busy_cnt != STREAM_END - 1) begin
            fails++;
            $display("FAIL %s busy length: got %0d want %0d", tag, busy_cnt, STREAM_END - 1);
        end
        tests++;
        if (done_cnt != 1 || done_at != STREAM_END) begin
            fails++;
            $display("FAIL %s done pulse: got %0d pulses at T+%0d want 1 at T+%0d", tag, done_cnt, done_at, STREAM_END);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL post_reset busy/done: got %b/%b want 0/0", busy_o, done_o);
        end
    endtask

    task automatic test_zero_stream();
        for (int k = 0; k < FILTER_NUM; k++) write_entry(k, 8'h00, '0);
        idle(2);
        run_stream("zero", -1, 0, 8'h00, -1);
    endtask

    task automatic load_pattern();
        for (int k = 0; k < FILTER_NUM; k++) write_entry(k, 8'(k + 1), BIAS_W'(100 + k));
        idle(2);
    endtask

    task automatic test_load_stream();
        load_pattern();
        tests++;
        if (weight_o[7:0] !== 8'd1 || weight_o[WW-1 -: 8] !== 8'd1 || bias_o !== 16'd100) begin
            fails++;
            $display("FAIL idle_stage: got %h/%0d want 01/100", weight_o[7:0], bias_o);
        end
        run_stream("basic", -1, 0, 8'h00, -1);
    endtask

    task automatic test_back_to_back();
        run_stream("b2b_first", -1, 0, 8'h00, -1);
        run_stream("b2b_second", -1, 0, 8'h00, -1);
        tests++;
        if (overrun_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b overrun: got %b want 0", overrun_o);
        end
    endtask

    task automatic test_rewrite();
        run_stream("rewrite_e5", 50, 5, 8'hAA, -1);
        run_stream("rewrite_e0", 50, 0, 8'hAA, -1);
        run_stream("rewrite_next", -1, 0, 8'h00, -1);
        tests++;
        if (pres_w[0] !== {IN_CH{8'hAA}}) begin
            fails++;
            $display("FAIL rewrite_e0 expectation: got %h want aa..", pres_w[0][31:0]);
        end
        idle(1);
        write_entry(0, 8'd1, 16'd100);
        write_entry(5, 8'd6, 16'd105);
        idle(2);
    endtask

    task automatic test_overrun();
        tests++;
        if (overrun_o !== 1'b0) begin
            fails++;
            $display("FAIL overrun_pre: got %b want 0", overrun_o);
        end
        run_stream("overrun", -1, 0, 8'h00, 100);
        idle(3);
        tests++;
`ifdef PW_FEEDER_ERR_EN
        if (overrun_o !== 1'b1) begin
            fails++;
            $display("FAIL overrun_sticky: got %b want 1", overrun_o);
        end
`else
        if (overrun_o !== 1'b0) begin
            fails++;
            $display("FAIL overrun_tied: got %b want 0", overrun_o);
        end
`endif
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1;
        for (int e = 0; e < 300; e++) begin
            @(posedge clk);
            @(negedge clk);
            start_i = 1'b0;
        end
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL mid_busy: got %b want 1", busy_o);
        end
        rst_n = 1'b0;
        #1;
        check_quiet("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        run_stream("after_reset", -1, 0, 8'h00, -1);
    endtask

    initial begin
        for (int k = 0; k < FILTER_NUM; k++) begin
            mdl_w[k] = '0;
            mdl_b[k] = '0;
        end
        test_reset();
        test_zero_stream();
        idle(2);
        test_load_stream();
        idle(2);
        test_back_to_back();
        idle(2);
        test_rewrite();
        test_overrun();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pw_weight_feeder.md
# pw_weight_feeder

Weight/bias streamer that drives the pointwise-convolution stage of the DSCNN 3rd layer. It holds one 1×1 filter row (IN_CH int8 weights) and one bias per output filter in a small register file loaded over a write port. On each layer start it presents the filters in order, exactly on the cadence at which the pointwise stage samples its weight/bias inputs: at start, then every 18 cycles. It sits between the parameter loader and the pointwise top, and observes the same start strobe that the pointwise stage observes.

## Interface
- DATA_W, 8, weight element width (int8)
- IN_CH, 32, weights per filter (1×1 kernel, one per input channel)
- BIAS_W, 16, bias width
- FILTER_NUM, 32, filters per layer pass; legal range 2..64
- PHASE_LEN, 18, cycles per filter slot; must match the pointwise stage's fine counter
- clk  in  1  clock; one clock
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  layer start strobe; same signal as the pointwise valid input
- wr_en_i  in  1  register-file write strobe
- wr_addr_i  in  $clog2(FILTER_NUM)  filter index to write
- wr_weight_i  in  IN_CH*DATA_W  filter weights; channel 0 in the LSBs
- wr_bias_i  in  BIAS_W  filter bias
- weight_o  out  IN_CH*DATA_W  presented filter; reset 0
- bias_o  out  BIAS_W  presented bias; reset 0
- busy_o  out  1  streaming in progress; reset 0
- done_o  out  1  one-cycle pulse at end of stream; reset 0
- overrun_o  out  1  sticky protocol error; reset 0

## Operation
- States: IDLE, RUN, TAIL.
- IDLE: weight_o/bias_o continuously show entry 0, re-registered each cycle so that writes to entry 0 appear on the next cycle. phase=0, idx=0.
- start_i in IDLE: go to RUN; phase←1, idx←0, busy_o←1. The consumer samples entry 0 on this same edge.
- RUN: phase counts 1..PHASE_LEN, then wraps to 1.
  - At the edge where phase==PHASE_LEN-2 and idx<FILTER_NUM-1: idx←idx+1 and output registers ← entry idx+1. The new filter is therefore stable while phase==PHASE_LEN-1 and is sampled by the consumer on that edge.
  - When idx==FILTER_NUM-1 and the phase==PHASE_LEN-1 edge is taken: go to TAIL.
- TAIL: outputs hold the last filter for PHASE_LEN cycles, covering the consumer's final compute pass. Then return to IDLE, with:
  - done_o pulsed for one cycle
  - busy_o←0
  - entry 0 re-staged on that same edge.
- Writes are accepted in every state. A write to an entry already latched into the output registers does not alter the outputs until that entry is next fetched. A write to a future entry is honored.
- A simultaneous write and fetch of the same entry presents the old data; the write still lands in the register file.
- start_i in RUN or TAIL is ignored (no restart) and sets overrun_o when the error feature is compiled in.
- Reset mid-stream: all state, outputs and overrun_o are cleared asynchronously. Register-file contents are not reset.

## Timing
- Start edge T (start_i sampled high).
  - Filter 0 is valid at edge T.
  - Filter k (k≥1) is driven from edge T+18k−2 and sampled at edge T+18k−1.
- Last filter sampled at edge T+18·FILTER_NUM−19.
- done_o high in the cycle following edge T+18·FILTER_NUM−1; busy_o falls at that same edge. For the default configuration this is T+575.
- Earliest legal next start: the edge after done_o.
- Write latency into the register file: 1 cycle.

## Configuration
- PW_FEEDER_ERR_EN defined: overrun_o is set by start_i while busy and cleared only by reset.
- PW_FEEDER_ERR_EN undefined: overrun_o is tied to 0 and no detection logic is built; a start while busy is still ignored.

## Structure
- Shared package holds:
  - the state encoding (IDLE/RUN/TAIL)
  - the PHASE_LEN default
  - the phase comparison constants (PHASE_LEN−2, PHASE_LEN−1)
- One sub-module is natural: pw_param_rf, the FILTER_NUM × (IN_CH*DATA_W+BIAS_W) register file with one write port and one read port.

## Test plan
- Load entry k with all weight bytes = k+1 and bias = 100+k; start at T → at edges T, T+17, T+35 … T+557 the outputs read bytes 1, 2, 3 … 32 and biases 100 … 131; done_o at T+576; busy_o low from T+575.
- After reset with no writes, start → outputs all-zero throughout, busy_o for 575 cycles, one done_o pulse.
- start_i again at T+100 with PW_FEEDER_ERR_EN defined → no restart, sequence timing unchanged, overrun_o=1 until reset. Without the macro → overrun_o stays 0.
- Rewrite entry 5 at T+50 with bytes 0xAA → sampled value at T+89 is 0xAA. Rewrite entry 0 at T+50 → no effect until the next start, then 0xAA is presented at that start.
- Deassert rst_n at T+300 → all outputs 0 immediately. After release, start → the sequence restarts from filter 0 with the previously loaded contents.
- Two back-to-back layers, second start on the cycle after done_o → identical sample sequence, no overrun.
